// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Package : counter_pkg
// Brief   : Shared constants, BCD digit type and 4-digit BCD step functions
//           for the button-controlled BCD counter.
// Rev     : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int c_BTN_UD    = 0;
    localparam int c_BTN_SPEED = 1;
    localparam int c_BTN_PAUSE = 2;
    localparam int c_NUM_BTN   = 3;

    typedef logic [3:0] bcd_digit_t;

    // Out-of-range digits are treated as 9 so the result is always legal BCD.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] val);
        logic [15:0] res;
        logic        carry;
        bcd_digit_t  d;
        res   = val;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = val[i*4 +: 4];
            if (carry) begin
                if (d >= 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                    carry         = 1'b1;
                end else begin
                    res[i*4 +: 4] = d + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] bcd4_dec(input logic [15:0] val);
        logic [15:0] res;
        logic        borrow;
        bcd_digit_t  d;
        res    = val;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = val[i*4 +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    res[i*4 +: 4] = 4'd9;
                    borrow        = 1'b1;
                end else if (d > 4'd9) begin
                    res[i*4 +: 4] = 4'd8;
                    borrow        = 1'b0;
                end else begin
                    res[i*4 +: 4] = d - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : Two-flop synchroniser, counter debouncer and rising-edge press
//          detector for one raw push-button.
// Rev    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int                 c_CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_differ;
    logic               w_flip;

    assign w_differ = (r_sync2 != r_level);
    assign w_flip   = w_differ && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    // Press is combinational so the owner's flag toggles on the same edge the level rises.
    assign level = r_level;
    assign press = w_flip & ~r_level;

endmodule
`default_nettype wire

// File: rtl/btn_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module : btn_bcd_counter
// Brief  : 4-digit BCD up/down counter with debounced direction, speed and
//          pause buttons and an internal slow/fast tick prescaler.
// Rev    : 1.0 - initial release
// ============================================================================
module btn_bcd_counter
    import counter_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int FAST_SHIFT = 2,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_ud,
    input  logic        btn_speed,
    input  logic        btn_pause,
    output logic [15:0] digits,
    output logic        dir,
    output logic        fast,
    output logic        paused,
    output logic        tick
);

    localparam int                 c_PRE_W     = $clog2(TICK_DIV);
    localparam logic [c_PRE_W-1:0] c_SLOW_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_FAST_LAST = c_PRE_W'((TICK_DIV >> FAST_SHIFT) - 1);

    logic [c_NUM_BTN-1:0] w_raw;
    logic [c_NUM_BTN-1:0] w_press;
    // Debounced levels are not needed here; only press edges drive the flags.
    logic [c_NUM_BTN-1:0] w_level_unused;

    logic [c_PRE_W-1:0]   r_presc;
    logic [15:0]          r_digits;
    logic                 r_dir;
    logic                 r_fast;
    logic                 r_paused;
    logic                 r_tick;

    logic [c_PRE_W-1:0]   w_last;
    logic                 w_wrap;

    assign w_raw[c_BTN_UD]    = btn_ud;
    assign w_raw[c_BTN_SPEED] = btn_speed;
    assign w_raw[c_BTN_PAUSE] = btn_pause;

    for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (w_raw[gi]),
            .level (w_level_unused[gi]),
            .press (w_press[gi])
        );
    end

    // All decisions use the pre-press flags, so a press never alters a coincident tick.
    assign w_last = r_fast ? c_FAST_LAST : c_SLOW_LAST;
    assign w_wrap = !r_paused && (r_presc == w_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_digits <= 16'h0000;
            r_dir    <= DIR_UP;
            r_fast   <= 1'b0;
            r_paused <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_wrap;

            if (w_wrap) begin
                r_digits <= (r_dir == DIR_DOWN) ? bcd4_dec(r_digits) : bcd4_inc(r_digits);
            end

            if (w_press[c_BTN_SPEED] || w_wrap) begin
                r_presc <= '0;
            end else if (!r_paused) begin
                r_presc <= r_presc + c_PRE_W'(1);
            end

            if (w_press[c_BTN_UD]) begin
                r_dir <= ~r_dir;
            end
            if (w_press[c_BTN_SPEED]) begin
                r_fast <= ~r_fast;
            end
            if (w_press[c_BTN_PAUSE]) begin
                r_paused <= ~r_paused;
            end
        end
    end

    assign digits = r_digits;
    assign dir    = r_dir;
    assign fast   = r_fast;
    assign paused = r_paused;
    assign tick   = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_btn_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module : tb_btn_bcd_counter
// Brief  : Directed self-checking bench for btn_bcd_counter (TICK_DIV=8,
//          FAST_SHIFT=1, DEB_CYCLES=4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_btn_bcd_counter;

    logic        clk;
    logic        reset;
    logic        btn_ud;
    logic        btn_speed;
    logic        btn_pause;
    logic [15:0] digits;
    logic        dir;
    logic        fast;
    logic        paused;
    logic        tick;

    int n_checks;
    int n_errors;
    int seen;

    logic [15:0] exp_up [10] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                                 16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h0010};
    logic [15:0] exp_dn [10] = '{16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004,
                                 16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'h9999};

    btn_bcd_counter #(
        .TICK_DIV   (8),
        .FAST_SHIFT (1),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_ud    (btn_ud),
        .btn_speed (btn_speed),
        .btn_pause (btn_pause),
        .digits    (digits),
        .dir       (dir),
        .fast      (fast),
        .paused    (paused),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        btn_ud    = 1'b0;
        btn_speed = 1'b0;
        btn_pause = 1'b0;

        // Reset state
        step(2);
        check_eq("rst_digits", digits, 16'h0000);
        check_eq("rst_dir", 16'(dir), 16'd0);
        check_eq("rst_fast", 16'(fast), 16'd0);
        check_eq("rst_paused", 16'(paused), 16'd0);
        check_eq("rst_tick", 16'(tick), 16'd0);
        reset = 1'b0;

        // Free run: slow ticks exactly 8 cycles apart, BCD carry at 0009 -> 0010
        for (int i = 0; i < 10; i++) begin
            step(7);
            check_eq("up_gap", 16'(tick), 16'd0);
            step(1);
            check_eq("up_tick", 16'(tick), 16'd1);
            check_eq("up_digits", digits, exp_up[i]);
        end

        // Direction press: toggles 5 edges after first sample, next tick counts down
        btn_ud = 1'b1;
        step(6);
        check_eq("ud_dir_down", 16'(dir), 16'd1);
        check_eq("ud_no_tick", 16'(tick), 16'd0);
        step(2);
        check_eq("dn_first_tick", 16'(tick), 16'd1);
        check_eq("dn_first", digits, 16'h0009);
        btn_ud = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step(8);
            check_eq("dn_tick", 16'(tick), 16'd1);
            check_eq("dn_digits", digits, exp_dn[j]);
        end

        // Back to up at 9999: wraps to 0000
        btn_ud = 1'b1;
        step(6);
        check_eq("ud_dir_up", 16'(dir), 16'd0);
        step(2);
        check_eq("wrap_tick", 16'(tick), 16'd1);
        check_eq("wrap_up", digits, 16'h0000);
        btn_ud = 1'b0;

        // Speed glitch of 2 cycles is rejected
        btn_speed = 1'b1;
        step(2);
        btn_speed = 1'b0;
        step(6);
        check_eq("glitch_fast", 16'(fast), 16'd0);
        check_eq("glitch_tick", 16'(tick), 16'd1);
        check_eq("glitch_digits", digits, 16'h0001);

        // Held speed press: fast at k+5, prescaler cleared, ticks 4 apart
        btn_speed = 1'b1;
        step(6);
        check_eq("fast_on", 16'(fast), 16'd1);
        check_eq("fast_no_tick", 16'(tick), 16'd0);
        step(3);
        check_eq("fast_gap", 16'(tick), 16'd0);
        step(1);
        check_eq("fast_tick1", 16'(tick), 16'd1);
        check_eq("fast_digits1", digits, 16'h0002);
        btn_speed = 1'b0;
        step(4);
        check_eq("fast_tick2", 16'(tick), 16'd1);
        check_eq("fast_digits2", digits, 16'h0003);
        step(2);
        btn_speed = 1'b1;
        step(2);
        check_eq("fast_tick3", 16'(tick), 16'd1);
        check_eq("fast_digits3", digits, 16'h0004);

        // Speed press coincident with a tick: tick counts at the old rate, prescaler restarts
        step(4);
        check_eq("spd_coinc_tick", 16'(tick), 16'd1);
        check_eq("spd_coinc_digits", digits, 16'h0005);
        check_eq("spd_coinc_fast", 16'(fast), 16'd0);
        btn_speed = 1'b0;
        step(7);
        check_eq("slow_gap", 16'(tick), 16'd0);
        step(1);
        check_eq("slow_tick", 16'(tick), 16'd1);
        check_eq("slow_digits", digits, 16'h0006);

        // Pause with prescaler held at 3, resume gives tick 5 cycles later
        step(5);
        btn_pause = 1'b1;
        step(3);
        check_eq("pre_pause_tick", 16'(tick), 16'd1);
        check_eq("pre_pause_digits", digits, 16'h0007);
        step(3);
        check_eq("paused_on", 16'(paused), 16'd1);
        btn_pause = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick) seen++;
        end
        check_eq("paused_no_tick", 16'(seen), 16'd0);
        check_eq("paused_digits", digits, 16'h0007);
        btn_pause = 1'b1;
        step(6);
        check_eq("paused_off", 16'(paused), 16'd0);
        btn_pause = 1'b0;
        step(4);
        check_eq("resume_gap", 16'(tick), 16'd0);
        step(1);
        check_eq("resume_tick", 16'(tick), 16'd1);
        check_eq("resume_digits", digits, 16'h0008);

        // Direction toggles on a tick edge: that tick counts up, the next down
        step(2);
        btn_ud = 1'b1;
        step(6);
        check_eq("ud_coinc_tick", 16'(tick), 16'd1);
        check_eq("ud_coinc_digits", digits, 16'h0009);
        check_eq("ud_coinc_dir", 16'(dir), 16'd1);
        btn_ud = 1'b0;
        step(8);
        check_eq("ud_after_tick", 16'(tick), 16'd1);
        check_eq("ud_after_digits", digits, 16'h0008);

        // Speed and pause pressed together: both take effect
        btn_speed = 1'b1;
        btn_pause = 1'b1;
        step(6);
        check_eq("multi_fast", 16'(fast), 16'd1);
        check_eq("multi_paused", 16'(paused), 16'd1);
        check_eq("multi_dir", 16'(dir), 16'd1);
        check_eq("multi_tick", 16'(tick), 16'd0);
        check_eq("multi_digits", digits, 16'h0008);
        btn_speed = 1'b0;
        btn_pause = 1'b0;
        step(3);

        // Asynchronous reset mid-cycle
        reset = 1'b1;
        #1;
        check_eq("arst_digits", digits, 16'h0000);
        check_eq("arst_dir", 16'(dir), 16'd0);
        check_eq("arst_fast", 16'(fast), 16'd0);
        check_eq("arst_paused", 16'(paused), 16'd0);
        check_eq("arst_tick", 16'(tick), 16'd0);
        step(2);
        reset = 1'b0;
        step(7);
        check_eq("post_rst_gap", 16'(tick), 16'd0);
        step(1);
        check_eq("post_rst_tick", 16'(tick), 16'd1);
        check_eq("post_rst_digits", digits, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_bcd_counter.md
# btn_bcd_counter

Button-controlled 4-digit BCD up/down counter that feeds the display stage: its digit bus is multiplexed onto the 7-segment display by the 2-bit scan counter and digit mux downstream. Three raw push-buttons (direction, speed, pause) are synchronised, debounced and edge-detected, and each press toggles a mode flag. An internal prescaler produces a 1 Hz or fast-rate count tick.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clk cycles per slow tick (1 Hz at 50 MHz); must be ≥ 2^FAST_SHIFT·2
- FAST_SHIFT, 2: fast period = TICK_DIV >> FAST_SHIFT
- DEB_CYCLES, 500_000: cycles an input must differ from its debounced level before it is accepted (≥ 1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- btn_ud  in  1  raw button, asynchronous; press toggles direction
- btn_speed  in  1  raw button; press toggles slow/fast
- btn_pause  in  1  raw button; press toggles run/pause
- digits  out  16  BCD, [15:12] thousands … [3:0] units
- dir  out  1  0 = up, 1 = down
- fast  out  1  1 = fast rate
- paused  out  1  1 = counting halted
- tick  out  1  one-cycle pulse on each edge where digits advances

## Operation
- Reset (async assert, sync use): digits=16'h0000, dir=0, fast=0, paused=0, tick=0, prescaler=0, all sync/debounce state 0.
- Button path, per button: 2-FF synchroniser → debouncer. Debounce counter increments while synced level ≠ debounced level and clears otherwise. When it reaches DEB_CYCLES−1 and the levels still differ, the debounced level flips on the next edge. A 0→1 flip is a press; a 1→0 flip is ignored.
- A press toggles its flag on the same edge the debounced level rises.
- Prescaler: counts 0 … P−1, with P = fast ? TICK_DIV>>FAST_SHIFT : TICK_DIV. At P−1 it wraps to 0 and asserts tick (registered) for that cycle.
- Prescaler holds its value while paused=1 and resumes from the held value.
- A speed press clears the prescaler to 0.
- On tick with dir=0, digits increments in BCD: a units digit of 9 rolls to 0 with carry, and 9999 wraps to 0000.
- On tick with dir=1, digits decrements in BCD: a digit of 0 rolls to 9 with borrow, and 0000 wraps to 9999.
- Every digit value is always 0–9.
- Simultaneous events:
  - tick coincident with any press: the tick counts using the pre-press dir/fast.
  - speed press plus tick: the prescaler goes to 0.
  - pause press plus tick: the tick counts, then the counter halts.
  - Presses on several buttons on the same edge all take effect.

## Timing
- Raw button rising, first sampled high at edge k and held stable: flag toggles at edge k+1+DEB_CYCLES (2 sync edges plus DEB_CYCLES−1 count edges).
- Glitches shorter than DEB_CYCLES cycles after sync are rejected.
- tick high exactly one cycle per period; digits updates on that same edge and is valid the cycle tick is high.
- Slow tick spacing is exactly TICK_DIV cycles; fast spacing is TICK_DIV>>FAST_SHIFT cycles.
- After un-pause, the first tick arrives after the remaining (P−1−held) + 1 cycles.
- Reset mid-operation: outputs go to reset values immediately. The first tick after release arrives TICK_DIV cycles later.

## Structure
- Package counter_pkg holds:
  - DIR_UP/DIR_DOWN constants
  - BCD digit type (4-bit)
  - functions bcd4_inc / bcd4_dec (16-bit in, 16-bit out, wrap included)
- Sub-module btn_debounce (params DEB_CYCLES; ports clk, reset, raw, level, press), instantiated three times.
- Top holds the flags, prescaler and BCD register.

## Test plan
Bench parameters: TICK_DIV=8, FAST_SHIFT=1, DEB_CYCLES=4.
- Reset then free run for 80 cycles → tick every 8 cycles; digits 0000→0001…→000A never occurs; 0009→0010 after 10 ticks.
- Preload via 9999 up-count (or force) then 1 tick → 0000; btn_ud press at 0000, then 1 tick → dir=1, digits=9999.
- btn_speed 2-cycle glitch → no change; held 10 cycles → fast=1 at edge k+5, prescaler 0, next ticks 4 cycles apart.
- btn_pause press mid-period (prescaler=3) → no tick while paused; second press → next tick exactly 5 cycles later.
- btn_ud press timed so the flag toggles on a tick edge → that tick counts up; the next tick counts down.
- Assert reset while fast, down, paused, digits=0123 → all outputs 0 immediately; after release, first tick at cycle 8.
